mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  Memory stage directly downstream of the execute stage (ALU/pcadder).
//  Consumes the ALU result as address (loads/stores) or as pass-through data (other ops).
//  Drives a single-port data-memory req/ready interface and hands formatted results to writeback.
//  Generates a stall back to execute while a memory access is outstanding.
// PARAMETERS
//  ADDR_W       12   data address width; address = ex_result[ADDR_W-1:0]
//  DATA_W       32   datapath width; fixed 32, byte lanes = DATA_W/8
//  MEM_TIMEOUT  255  cycles in REQ with no mem_ready before a bus-timeout exception (>=1)
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       synchronous, active-high reset
//  ex_valid      in   1       execute output valid
//  ex_result     in   32      ALU result: address or writeback data
//  ex_store_data in   32      rs2 value for stores
//  ex_mem_read   in   1       load
//  ex_mem_write  in   1       store (mem_read & mem_write both set = illegal)
//  ex_funct3     in   3       size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_rd         in   5       destination register
//  ex_reg_write  in   1       writeback enable
//  flush         in   1       kill current/incoming instruction's writeback
//  stall_out     out  1       high = execute must hold its outputs
//  mem_req       out  1       memory request
//  mem_we        out  1       1 = write
//  mem_addr      out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_wdata     out  32      lane-replicated store data
//  mem_be        out  4       byte enables
//  mem_ready     in   1       memory completed request this cycle
//  mem_rdata     in   32      read word, valid when mem_ready & ~mem_we
//  wb_valid      out  1       one-cycle pulse per retired instruction
//  wb_data       out  32      load data (extended) or ex_result
//  wb_rd         out  5       destination register
//  wb_reg_write  out  1       gated: 0 on exception, flush, rd==0
//  exc_valid     out  1       pulses with wb_valid on exception
//  exc_cause     out  2       01 misaligned, 10 bus timeout, 11 illegal size/op
//  exc_addr      out  ADDR_W  faulting byte address
// BEHAVIOUR
//  - Reset: state IDLE, timeout counter 0; all outputs 0 at the first edge with rst high.
//    An in-flight mem_req drops that edge and the request is abandoned (no wb, no exc).
//  - FSM IDLE/REQ.
//    Accept when ex_valid & ~stall_out; stall_out = (state==REQ), combinational.
//  - IDLE, accept, non-memory op: wb_valid next cycle, wb_data=ex_result; stays IDLE (1-cycle latency).
//  - IDLE, accept, memory op:
//    - Checks: illegal funct3 (load 011/11x, store >010) or read&write -> exc 11.
//    - Misaligned (H: addr[0]; W: addr[1:0]!=0) -> exc 01.
//    - On exception: no mem_req; wb_valid+exc_valid next cycle, wb_reg_write=0.
//    - Else register op, -> REQ.
//  - REQ: mem_req=1. mem_we/addr/wdata/be held stable until the cycle mem_ready is sampled high.
//    - Byte enables: B 0001<<addr[1:0]; H 0011<<addr[1:0]; W 1111.
//    - Store data: wdata = byte x4 / half x2 / word.
//    - On mem_ready: load lane selected by addr[1:0], sign-/zero-extended per funct3.
//      wb_valid next cycle, -> IDLE. Stores pulse wb_valid with wb_reg_write=0.
//    - Latency: accept T, req from T+1, ready at T+1+k (k>=0), wb at T+2+k.
//  - Timeout: counter increments each REQ cycle without ready.
//    Reaching MEM_TIMEOUT drops req -> exc 10, wb_reg_write=0, -> IDLE.
//    Counter clears on entering REQ.
//  - flush: in IDLE, incoming instruction discarded (no req, no wb).
//    In REQ, the issued request completes; its wb_valid/exc_valid are suppressed.
//  - mem_ready outside REQ is ignored. mem_ready together with the timeout limit -> ready wins.
//  - wb_reg_write forced 0 when rd==0.
// STRUCTURE
//  - Package riscv_mem_pkg:
//    - funct3 localparams (F3_B/H/W/BU/HU)
//    - state_t enum {IDLE,REQ}
//    - exc_cause_t (EXC_NONE, EXC_MISALIGN, EXC_TIMEOUT, EXC_ILLEGAL)
//  - Sub-module lsu_align (combinational): funct3+addr[1:0]+data -> be/wdata,
//    and rdata -> extended load value.
// TESTING
//  - ALU op ex_result=0x0000_1234, rd=5 -> wb_valid 1 cycle later, wb_data=0x1234, no mem_req.
//  - LB addr 0x003, rdata=0x80FF_FF7F, ready on 3rd REQ cycle ->
//    stall 3 cycles, wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
//  - SH addr 0x006, store_data=0xAAAA_BEEF -> mem_be=1100, wdata=0xBEEF_BEEF,
//    addr=0x004, wb_reg_write=0.
//  - LW addr 0x002 -> no mem_req, exc_valid, exc_cause=01, exc_addr=0x002.
//  - MEM_TIMEOUT=4, never ready -> req high 4 cycles then drops, exc_cause=10, stall released.
//  - rst during REQ -> mem_req 0 next edge, no wb; flush during REQ -> access completes, wb_valid never pulses.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types for the memory-access stage.
// Load/store size encodings, FSM states and exception causes.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10,
    EXC_ILLEGAL  = 2'b11
  } exc_cause_t;

  function automatic logic ld_f3_ok(
    input logic [2:0] f3
  );
    return f3 inside {F3_B, F3_H, F3_W,
                      F3_BU, F3_HU};
  endfunction

  function automatic logic st_f3_ok(
    input logic [2:0] f3
  );
    return f3 inside {F3_B, F3_H, F3_W};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and
// load lane select with sign or zero extension.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_sdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_ldata
);

  logic [31:0] w_sh;
  logic [1:0]  w_sz;

  assign w_sh = i_rdata >> {i_off, 3'b000};
  assign w_sz = i_funct3[1:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_sdata;
    o_ldata = w_sh;
    unique case (1'b1)
      (w_sz == F3_B[1:0]): begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_sdata[7:0]}};
        o_ldata = i_funct3[2]
                ? {24'd0, w_sh[7:0]}
                : {{24{w_sh[7]}}, w_sh[7:0]};
      end
      (w_sz == F3_H[1:0]): begin
        o_be    = 4'b0011 << i_off;
        o_wdata = {2{i_sdata[15:0]}};
        o_ldata = i_funct3[2]
                ? {16'd0, w_sh[15:0]}
                : {{16{w_sh[15]}}, w_sh[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory requests, stalls execute
// while one is outstanding, and formats writeback results.
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  input  logic              flush,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic [ADDR_W-1:0] exc_addr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_sdata;
  logic [4:0]        r_rd;
  logic              r_rw;
  logic              r_flushed;

  logic              w_accept;
  logic              w_is_mem;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_rd_ok;
  logic              w_kill;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ldata;

  lsu_align u_align (
    .i_funct3 (r_f3),
    .i_off    (r_res[1:0]),
    .i_sdata  (r_sdata),
    .i_rdata  (mem_rdata),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_ldata  (w_ldata)
  );

  assign stall_out = (r_state == REQ);
  assign w_accept  = ex_valid & ~stall_out & ~flush;
  assign w_is_mem  = ex_mem_read | ex_mem_write;
  assign w_rd_ok   = ex_reg_write & (|ex_rd);
  assign w_kill    = r_flushed | flush;

  assign w_illegal =
      (ex_mem_read & ex_mem_write)
    | (ex_mem_read & ~ld_f3_ok(ex_funct3))
    | (ex_mem_write & ~st_f3_ok(ex_funct3));

  assign w_misalign =
      ((ex_funct3[1:0] == F3_H[1:0]) & ex_result[0])
    | ((ex_funct3[1:0] == F3_W[1:0])
       & (|ex_result[1:0]));

  // Bus outputs come straight from registers, stable for the whole request.
  assign mem_req   = r_req;
  assign mem_we    = r_req & r_we;
  assign mem_addr  = {r_res[ADDR_W-1:2], 2'b00};
  assign mem_be    = r_req ? w_be : 4'b0000;
  assign mem_wdata = (r_req & r_we) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_f3         <= '0;
      r_res        <= '0;
      r_sdata      <= '0;
      r_rd         <= '0;
      r_rw         <= 1'b0;
      r_flushed    <= 1'b0;
      wb_valid     <= 1'b0;
      wb_data      <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      exc_valid    <= 1'b0;
      exc_cause    <= EXC_NONE;
      exc_addr     <= '0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept && !w_is_mem) begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= w_rd_ok;
            exc_cause    <= EXC_NONE;
          end else if (w_accept
                       && (w_illegal || w_misalign)) begin
            wb_valid     <= 1'b1;
            exc_valid    <= 1'b1;
            wb_data      <= ex_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= 1'b0;
            exc_cause    <= w_illegal ? EXC_ILLEGAL
                                      : EXC_MISALIGN;
            exc_addr     <= ex_result[ADDR_W-1:0];
          end else if (w_accept) begin
            r_state   <= REQ;
            r_req     <= 1'b1;
            r_cnt     <= '0;
            r_we      <= ex_mem_write;
            r_f3      <= ex_funct3;
            r_res     <= ex_result;
            r_sdata   <= ex_store_data;
            r_rd      <= ex_rd;
            r_rw      <= w_rd_ok & ex_mem_read;
            r_flushed <= 1'b0;
          end
        end
        REQ: begin
          r_flushed <= w_kill;
          if (mem_ready) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            wb_valid     <= ~w_kill;
            wb_data      <= r_we ? r_res : w_ldata;
            wb_rd        <= r_rd;
            wb_reg_write <= r_rw & ~w_kill;
            exc_cause    <= EXC_NONE;
          end else if (r_cnt == LIMIT) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            wb_valid     <= ~w_kill;
            exc_valid    <= ~w_kill;
            wb_data      <= r_res;
            wb_rd        <= r_rd;
            wb_reg_write <= 1'b0;
            exc_cause    <= EXC_TIMEOUT;
            exc_addr     <= r_res[ADDR_W-1:0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a writeback
// scoreboard drained by an independent monitor.
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
    logic        rw;
    logic        exc;
    logic [1:0]  cause;
    logic [11:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [31:0] ex_result, ex_store_data;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, flush;
  logic        stall_out, mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_reg_write, exc_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [1:0]  exc_cause;
  logic [11:0] exc_addr;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  mem_access_stage #(
    .ADDR_W(12), .DATA_W(32), .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data),
    .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .flush(flush),
    .stall_out(stall_out), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_addr(exc_addr)
  );

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, x);
    end
  endtask

  function automatic exp_t mk(
    input logic [31:0] d, input logic [4:0] rd,
    input logic rw, input logic exc,
    input logic [1:0] cause, input logic [11:0] a);
    exp_t r;
    r.d = d; r.rd = rd; r.rw = rw;
    r.exc = exc; r.cause = cause; r.addr = a;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst && (wb_valid || exc_valid)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wb got data=%h exc=%b",
                 wb_data, exc_valid);
      end else begin
        e = q.pop_front();
        chk("wb_valid", {31'd0, wb_valid}, 32'd1);
        chk("wb_data", wb_data, e.d);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_reg_write", {31'd0, wb_reg_write},
            {31'd0, e.rw});
        chk("exc_valid", {31'd0, exc_valid},
            {31'd0, e.exc});
        if (e.exc) begin
          chk("exc_cause", {30'd0, exc_cause},
              {30'd0, e.cause});
          chk("exc_addr", {20'd0, exc_addr},
              {20'd0, e.addr});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [31:0] res,
                     input logic [4:0] rd,
                     input logic rw, input logic fl);
    ex_valid = 1'b1; ex_result = res;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_rd = rd; ex_reg_write = rw; flush = fl;
    if (!fl) q.push_back(mk(res, rd, rw && rd != 0,
                            1'b0, 2'b00, 12'h0));
    step();
    ex_valid = 1'b0; flush = 1'b0;
    chk("alu_no_req", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic mem_op(input logic rd_, input logic wr_,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input logic [4:0] rd,
                        input logic fl);
    ex_valid = 1'b1; ex_result = a; ex_store_data = sd;
    ex_mem_read = rd_; ex_mem_write = wr_;
    ex_funct3 = f3; ex_rd = rd; ex_reg_write = 1'b1;
    flush = fl;
    step();
    ex_valid = 1'b0; flush = 1'b0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic finish_req(input int k,
                            input logic [31:0] rdata);
    for (int i = 0; i <= k; i++) begin
      chk("stall_in_req", {31'd0, stall_out}, 32'd1);
      chk("req_in_req", {31'd0, mem_req}, 32'd1);
      if (i == k) begin
        mem_ready = 1'b1;
        mem_rdata = rdata;
      end
      step();
    end
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    chk("stall_release", {31'd0, stall_out}, 32'd0);
    chk("req_drop", {31'd0, mem_req}, 32'd0);
  endtask

  task automatic load(input logic [2:0] f3,
                      input logic [11:0] a,
                      input logic [31:0] rdata,
                      input int k,
                      input logic [31:0] exp_d,
                      input logic [3:0] exp_be);
    mem_op(1'b1, 1'b0, f3, {20'd0, a}, 32'h0, 5'd7, 1'b0);
    chk("ld_addr", {20'd0, mem_addr},
        {20'd0, a[11:2], 2'b00});
    chk("ld_be", {28'd0, mem_be}, {28'd0, exp_be});
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    q.push_back(mk(exp_d, 5'd7, 1'b1, 1'b0, 2'b00, 12'h0));
    finish_req(k, rdata);
  endtask

  task automatic store(input logic [2:0] f3,
                       input logic [11:0] a,
                       input logic [31:0] sd,
                       input logic [31:0] exp_wd,
                       input logic [3:0] exp_be);
    mem_op(1'b0, 1'b1, f3, {20'd0, a}, sd, 5'd3, 1'b0);
    chk("st_addr", {20'd0, mem_addr},
        {20'd0, a[11:2], 2'b00});
    chk("st_be", {28'd0, mem_be}, {28'd0, exp_be});
    chk("st_wdata", mem_wdata, exp_wd);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    q.push_back(mk({20'd0, a}, 5'd3, 1'b0, 1'b0,
                   2'b00, 12'h0));
    finish_req(1, 32'h0);
  endtask

  task automatic bad_op(input logic rd_, input logic wr_,
                        input logic [2:0] f3,
                        input logic [11:0] a,
                        input logic [1:0] cause);
    mem_op(rd_, wr_, f3, {20'd0, a}, 32'h0, 5'd9, 1'b0);
    q.push_back(mk({20'd0, a}, 5'd9, 1'b0, 1'b1,
                   cause, a));
    chk("exc_no_req", {31'd0, mem_req}, 32'd0);
    chk("exc_no_stall", {31'd0, stall_out}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; ex_result = '0;
    ex_store_data = '0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; flush = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;
    step();
    step();
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_wb", {31'd0, wb_valid}, 32'd0);
    chk("rst_exc", {31'd0, exc_valid}, 32'd0);
    chk("rst_be", {28'd0, mem_be}, 32'd0);
    rst = 1'b0;
    step();

    alu(32'h0000_1234, 5'd5, 1'b1, 1'b0);
    alu(32'h0000_5555, 5'd0, 1'b1, 1'b0);
    alu(32'h0000_9999, 5'd6, 1'b1, 1'b1);
    step();

    load(3'b000, 12'h003, 32'h80FF_FF7F, 2,
         32'hFFFF_FF80, 4'b1000);
    load(3'b100, 12'h003, 32'h80FF_FF7F, 0,
         32'h0000_0080, 4'b1000);
    load(3'b001, 12'h002, 32'h8001_1234, 1,
         32'hFFFF_8001, 4'b1100);
    load(3'b101, 12'h002, 32'h8001_1234, 0,
         32'h0000_8001, 4'b1100);
    load(3'b010, 12'h004, 32'hDEAD_BEEF, 1,
         32'hDEAD_BEEF, 4'b1111);
    load(3'b010, 12'h030, 32'h0BAD_F00D, 3,
         32'h0BAD_F00D, 4'b1111);

    store(3'b001, 12'h006, 32'hAAAA_BEEF,
          32'hBEEF_BEEF, 4'b1100);
    store(3'b000, 12'h001, 32'h1234_5678,
          32'h7878_7878, 4'b0010);
    store(3'b010, 12'h008, 32'h0102_0304,
          32'h0102_0304, 4'b1111);

    bad_op(1'b1, 1'b0, 3'b010, 12'h002, 2'b01);
    bad_op(1'b1, 1'b0, 3'b001, 12'h001, 2'b01);
    bad_op(1'b1, 1'b0, 3'b011, 12'h000, 2'b11);
    bad_op(1'b0, 1'b1, 3'b100, 12'h000, 2'b11);
    bad_op(1'b1, 1'b1, 3'b010, 12'h000, 2'b11);
    step();

    mem_op(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 5'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("to_req_high", {31'd0, mem_req}, 32'd1);
      step();
    end
    q.push_back(mk(32'h10, 5'd4, 1'b0, 1'b1,
                   2'b10, 12'h010));
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_stall_rel", {31'd0, stall_out}, 32'd0);
    step();

    mem_op(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 5'd4, 1'b0);
    chk("rst_mid_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    step();
    chk("rst_drop_req", {31'd0, mem_req}, 32'd0);
    chk("rst_drop_stall", {31'd0, stall_out}, 32'd0);
    rst = 1'b0;
    step();

    mem_op(1'b1, 1'b0, 3'b010, 32'h24, 32'h0, 5'd4, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_req_kept", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_2222;
    step();
    mem_ready = 1'b0;
    chk("flush_req_done", {31'd0, mem_req}, 32'd0);

    mem_op(1'b1, 1'b0, 3'b010, 32'h28, 32'h0, 5'd4, 1'b1);
    chk("flush_idle_req", {31'd0, mem_req}, 32'd0);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    step();
    chk("queue_empty", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
